// File: rtl/frost32_mem_access_unit_if.sv
// Shared Frost32 access-type/size encodings and the grouped request/bus
// signal bundle between the pipeline, the memory access unit and main memory.

package PkgFrost32Cpu;

    typedef enum logic [1:0] {
        Dias8  = 2'd0,
        Dias16 = 2'd1,
        Dias32 = 2'd2
    } DataInoutAccessSize;

    typedef enum logic {
        DiatRead  = 1'b0,
        DiatWrite = 1'b1
    } DataInoutAccessType;

endpackage

interface frost32_mem_access_unit_if;
    import PkgFrost32Cpu::*;

    logic               fetch_req;
    logic [31:0]        fetch_addr;
    logic               fetch_ack;
    logic [31:0]        fetch_data;
    logic               fetch_fault;

    logic               ls_req;
    logic               ls_write;
    DataInoutAccessSize ls_size;
    logic               ls_signed;
    logic [31:0]        ls_addr;
    logic [31:0]        ls_wdata;
    logic               ls_ack;
    logic [31:0]        ls_rdata;
    logic               ls_fault;

    logic               req_mem_access;
    logic [31:0]        addr;
    logic [31:0]        data_out;
    DataInoutAccessType data_inout_access_type;
    DataInoutAccessSize data_inout_access_size;
    logic [31:0]        data_in;

    logic               busy;

    // The access unit is the bus initiator; the slave view belongs to the
    // pipeline-plus-memory environment around it.
    modport master (
        input  fetch_req, fetch_addr,
        output fetch_ack, fetch_data, fetch_fault,
        input  ls_req, ls_write, ls_size, ls_signed, ls_addr, ls_wdata,
        output ls_ack, ls_rdata, ls_fault,
        output req_mem_access, addr, data_out,
        output data_inout_access_type, data_inout_access_size,
        input  data_in,
        output busy
    );

    modport slave (
        output fetch_req, fetch_addr,
        input  fetch_ack, fetch_data, fetch_fault,
        output ls_req, ls_write, ls_size, ls_signed, ls_addr, ls_wdata,
        input  ls_ack, ls_rdata, ls_fault,
        input  req_mem_access, addr, data_out,
        input  data_inout_access_type, data_inout_access_size,
        output data_in,
        input  busy
    );

endinterface

// File: rtl/frost32_mem_access_unit.sv
// Frost32 memory access unit: arbitrates fetch vs load/store onto the single
// memory bus, faults misaligned accesses and extends load results.

module frost32_mem_access_unit
    import PkgFrost32Cpu::*;
#(
    parameter int RESP_LATENCY = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    frost32_mem_access_unit_if.master bus
);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StDone
    } state_t;

    state_t             state_q;
    logic               isLs_q;
    logic               isSigned_q;
    logic [15:0]        cnt_q;

    logic               reqMem_q;
    logic [31:0]        busAddr_q;
    logic [31:0]        busData_q;
    DataInoutAccessType busType_q;
    DataInoutAccessSize busSize_q;
    logic               fetchAck_q;
    logic [31:0]        fetchData_q;
    logic               fetchFault_q;
    logic               lsAck_q;
    logic [31:0]        lsRdata_q;
    logic               lsFault_q;
    logic               busy_q;

    logic               capLs;
    logic               capWrite;
    logic [31:0]        capAddr;
    DataInoutAccessSize capSize;
    logic               capMisaligned;

    // Candidate capture in IDLE: load/store always wins over fetch.
    always_comb begin
        capLs         = bus.ls_req;
        capWrite      = bus.ls_req & bus.ls_write;
        capAddr       = bus.ls_req ? bus.ls_addr : bus.fetch_addr;
        capSize       = bus.ls_req ? bus.ls_size : Dias32;
        capMisaligned = ((capSize == Dias16) && capAddr[0]) ||
                        ((capSize == Dias32) && (capAddr[1:0] != 2'b00));
    end

    function automatic logic [31:0] extendLoad(input logic [31:0] raw,
                                               input DataInoutAccessSize sz,
                                               input logic sgn);
        logic [31:0] res;
        case (sz)
            Dias8:   res = {{24{sgn & raw[7]}}, raw[7:0]};
            Dias16:  res = {{16{sgn & raw[15]}}, raw[15:0]};
            default: res = raw;
        endcase
        return res;
    endfunction

    // Every visible output is a register updated on the transition into the
    // state where it must be valid, so acks land exactly in the DONE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            isLs_q       <= 1'b0;
            isSigned_q   <= 1'b0;
            cnt_q        <= '0;
            reqMem_q     <= 1'b0;
            busAddr_q    <= '0;
            busData_q    <= '0;
            busType_q    <= DiatRead;
            busSize_q    <= Dias8;
            fetchAck_q   <= 1'b0;
            fetchData_q  <= '0;
            fetchFault_q <= 1'b0;
            lsAck_q      <= 1'b0;
            lsRdata_q    <= '0;
            lsFault_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            reqMem_q     <= 1'b0;
            fetchAck_q   <= 1'b0;
            fetchFault_q <= 1'b0;
            lsAck_q      <= 1'b0;
            lsFault_q    <= 1'b0;

            case (state_q)
                StIdle: begin
                    if (bus.ls_req || bus.fetch_req) begin
                        isLs_q     <= capLs;
                        isSigned_q <= capLs & bus.ls_signed;
                        busy_q     <= 1'b1;
                        if (capMisaligned) begin
                            // Faults skip the bus entirely; bus outputs keep their old values.
                            state_q <= StDone;
                            if (capLs) begin
                                lsAck_q   <= 1'b1;
                                lsFault_q <= 1'b1;
                                lsRdata_q <= '0;
                            end else begin
                                fetchAck_q   <= 1'b1;
                                fetchFault_q <= 1'b1;
                                fetchData_q  <= '0;
                            end
                        end else begin
                            state_q   <= StIssue;
                            reqMem_q  <= 1'b1;
                            busAddr_q <= capAddr;
                            busData_q <= capLs ? bus.ls_wdata : 32'h0;
                            busType_q <= capWrite ? DiatWrite : DiatRead;
                            busSize_q <= capSize;
                        end
                    end
                end

                StIssue: begin
                    if (busType_q == DiatWrite) begin
                        state_q <= StDone;
                        lsAck_q <= 1'b1;
                    end else begin
                        state_q <= StWait;
                        cnt_q   <= 16'(RESP_LATENCY - 1);
                    end
                end

                StWait: begin
                    if (cnt_q == 16'd0) begin
                        state_q <= StDone;
                        if (isLs_q) begin
                            lsAck_q   <= 1'b1;
                            lsRdata_q <= extendLoad(bus.data_in, busSize_q, isSigned_q);
                        end else begin
                            fetchAck_q  <= 1'b1;
                            fetchData_q <= bus.data_in;
                        end
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end

                StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end

                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_mem_access         = reqMem_q;
    assign bus.addr                   = busAddr_q;
    assign bus.data_out               = busData_q;
    assign bus.data_inout_access_type = busType_q;
    assign bus.data_inout_access_size = busSize_q;
    assign bus.fetch_ack              = fetchAck_q;
    assign bus.fetch_data             = fetchData_q;
    assign bus.fetch_fault            = fetchFault_q;
    assign bus.ls_ack                 = lsAck_q;
    assign bus.ls_rdata               = lsRdata_q;
    assign bus.ls_fault               = lsFault_q;
    assign bus.busy                   = busy_q;

endmodule

// File: tb/tb_frost32_mem_access_unit.sv
// Scoreboard bench for frost32_mem_access_unit: a byte-addressed big-endian
// memory responder, queued ack/strobe expectations and cycle-accurate checks.

module tb_frost32_mem_access_unit;
    import PkgFrost32Cpu::*;

    localparam int LAT = 1;

    typedef struct {
        bit          isLs;
        logic [31:0] data;
        bit          chkData;
        bit          fault;
        int          cycle;
    } ackExp_t;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] data;
        bit          chkData;
    } strobeExp_t;

    logic clk;
    logic rst;
    frost32_mem_access_unit_if busIf();

    frost32_mem_access_unit #(.RESP_LATENCY(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (busIf)
    );

    logic [7:0] mem [0:511];
    ackExp_t    ackQ[$];
    strobeExp_t strobeQ[$];
    int         cycleCount = 0;
    int         strobeCount = 0;
    int         strobesPushed = 0;
    int         vectorCount = 0;
    int         miscompares = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // Memory responder: single process owning mem and data_in.
    initial begin
        logic [8:0] a;
        for (int i = 0; i < 512; i++) mem[i] = 8'h00;
        mem[9'h010] = 8'h11; mem[9'h011] = 8'h22; mem[9'h012] = 8'h33; mem[9'h013] = 8'h44;
        mem[9'h020] = 8'h7F; mem[9'h021] = 8'h80; mem[9'h022] = 8'h9A; mem[9'h023] = 8'hBC;
        mem[9'h000] = 8'hDE; mem[9'h001] = 8'hAD; mem[9'h002] = 8'hBE; mem[9'h003] = 8'hEF;
        mem[9'h100] = 8'hCA; mem[9'h101] = 8'hFE; mem[9'h102] = 8'hF0; mem[9'h103] = 8'h0D;
        forever begin
            @(posedge clk);
            if (busIf.req_mem_access === 1'b1) begin
                a = busIf.addr[8:0];
                if (busIf.data_inout_access_type == DiatWrite) begin
                    case (busIf.data_inout_access_size)
                        Dias8:  mem[a] = busIf.data_out[7:0];
                        Dias16: begin mem[a] = busIf.data_out[15:8]; mem[a + 9'd1] = busIf.data_out[7:0]; end
                        default: begin
                            mem[a]         = busIf.data_out[31:24];
                            mem[a + 9'd1]  = busIf.data_out[23:16];
                            mem[a + 9'd2]  = busIf.data_out[15:8];
                            mem[a + 9'd3]  = busIf.data_out[7:0];
                        end
                    endcase
                end else begin
                    case (busIf.data_inout_access_size)
                        Dias8:   busIf.data_in <= {24'h0, mem[a]};
                        Dias16:  busIf.data_in <= {16'h0, mem[a], mem[a + 9'd1]};
                        default: busIf.data_in <= {mem[a], mem[a + 9'd1], mem[a + 9'd2], mem[a + 9'd3]};
                    endcase
                end
            end
        end
    end

    task automatic handleAck(input bit src);
        ackExp_t e;
        if (ackQ.size() == 0) begin
            checkOutput(src ? "spuriousLsAck" : "spuriousFetchAck", 32'd1, 32'd0);
        end else begin
            e = ackQ.pop_front();
            checkOutput("ackSource", {31'b0, src}, {31'b0, e.isLs});
            checkOutput("ackCycle", 32'(cycleCount), 32'(e.cycle));
            checkOutput("ackFault", {31'b0, src ? busIf.ls_fault : busIf.fetch_fault}, {31'b0, e.fault});
            if (e.chkData)
                checkOutput("ackData", src ? busIf.ls_rdata : busIf.fetch_data, e.data);
        end
    endtask

    // Monitor samples on the falling edge, away from state changes.
    always @(negedge clk) begin
        strobeExp_t s;
        if (rst === 1'b0) begin
            if (busIf.ls_ack === 1'b1)    handleAck(1'b1);
            if (busIf.fetch_ack === 1'b1) handleAck(1'b0);
            if (busIf.req_mem_access === 1'b1) begin
                strobeCount++;
                if (strobeQ.size() == 0) begin
                    checkOutput("unexpectedStrobe", 32'd1, 32'd0);
                end else begin
                    s = strobeQ.pop_front();
                    checkOutput("strobeAddr", busIf.addr, s.addr);
                    checkOutput("strobeType", {31'b0, busIf.data_inout_access_type}, {31'b0, s.wr});
                    checkOutput("strobeSize", {30'b0, busIf.data_inout_access_size}, {30'b0, s.size});
                    if (s.chkData) checkOutput("strobeData", busIf.data_out, s.data);
                end
            end
        end
    end

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".req"},       {31'b0, busIf.req_mem_access}, 32'd0);
        checkOutput({tag, ".fetchAck"},  {31'b0, busIf.fetch_ack}, 32'd0);
        checkOutput({tag, ".lsAck"},     {31'b0, busIf.ls_ack}, 32'd0);
        checkOutput({tag, ".faults"},    {30'b0, busIf.fetch_fault, busIf.ls_fault}, 32'd0);
        checkOutput({tag, ".busy"},      {31'b0, busIf.busy}, 32'd0);
        checkOutput({tag, ".addr"},      busIf.addr, 32'd0);
        checkOutput({tag, ".dataOut"},   busIf.data_out, 32'd0);
        checkOutput({tag, ".lsRdata"},   busIf.ls_rdata, 32'd0);
        checkOutput({tag, ".fetchData"}, busIf.fetch_data, 32'd0);
        checkOutput({tag, ".type"},      {31'b0, busIf.data_inout_access_type}, 32'd0);
        checkOutput({tag, ".size"},      {30'b0, busIf.data_inout_access_size}, 32'd0);
    endtask

    // Called in an IDLE cycle just after a falling edge; returns in the next IDLE cycle.
    task automatic applyStimulus(input bit isLs, input bit wr, input DataInoutAccessSize sz,
                                 input bit sgn, input logic [31:0] a, input logic [31:0] wd,
                                 input logic [31:0] expData, input bit expFault);
        ackExp_t    e;
        strobeExp_t s;
        bit         seen;
        e.isLs    = isLs;
        e.data    = expData;
        e.chkData = !(isLs && wr && !expFault);
        e.fault   = expFault;
        e.cycle   = cycleCount + (expFault ? 1 : (wr ? 2 : 2 + LAT));
        ackQ.push_back(e);
        if (!expFault) begin
            s.addr = a; s.wr = wr; s.size = isLs ? sz : Dias32; s.data = wd; s.chkData = wr;
            strobeQ.push_back(s);
            strobesPushed++;
        end
        if (isLs) begin
            busIf.ls_write = wr; busIf.ls_size = sz; busIf.ls_signed = sgn;
            busIf.ls_addr = a; busIf.ls_wdata = wd; busIf.ls_req = 1'b1;
        end else begin
            busIf.fetch_addr = a; busIf.fetch_req = 1'b1;
        end
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = isLs ? busIf.ls_ack : busIf.fetch_ack;
        end
        if (!seen) checkOutput("ackTimeout", 32'd0, 32'd1);
        busIf.ls_req = 1'b0;
        busIf.fetch_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        ackExp_t    e;
        strobeExp_t s;
        bit         lsSeen, fetchSeen;

        busIf.fetch_req = 1'b0; busIf.fetch_addr = '0;
        busIf.ls_req = 1'b0; busIf.ls_write = 1'b0; busIf.ls_size = Dias8;
        busIf.ls_signed = 1'b0; busIf.ls_addr = '0; busIf.ls_wdata = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkAllZero("reset");
        rst = 1'b0;
        @(negedge clk);

        applyStimulus(1'b0, 1'b0, Dias32, 1'b0, 32'h10, 32'h0, 32'h11223344, 1'b0);
        applyStimulus(1'b1, 1'b0, Dias8,  1'b1, 32'h21, 32'h0, 32'hFFFFFF80, 1'b0);
        applyStimulus(1'b1, 1'b0, Dias8,  1'b0, 32'h21, 32'h0, 32'h00000080, 1'b0);
        applyStimulus(1'b1, 1'b0, Dias16, 1'b1, 32'h22, 32'h0, 32'hFFFF9ABC, 1'b0);
        applyStimulus(1'b1, 1'b0, Dias16, 1'b0, 32'h22, 32'h0, 32'h00009ABC, 1'b0);
        applyStimulus(1'b1, 1'b0, Dias32, 1'b1, 32'h20, 32'h0, 32'h7F809ABC, 1'b0);

        applyStimulus(1'b1, 1'b1, Dias16, 1'b0, 32'h40, 32'h1234ABCD, 32'h0, 1'b0);
        checkOutput("mem40", {24'h0, mem[9'h040]}, 32'hAB);
        checkOutput("mem41", {24'h0, mem[9'h041]}, 32'hCD);
        applyStimulus(1'b1, 1'b0, Dias16, 1'b0, 32'h40, 32'h0, 32'h0000ABCD, 1'b0);
        applyStimulus(1'b1, 1'b1, Dias8,  1'b0, 32'h45, 32'hFFFFFF77, 32'h0, 1'b0);
        applyStimulus(1'b1, 1'b0, Dias8,  1'b1, 32'h45, 32'h0, 32'h00000077, 1'b0);
        applyStimulus(1'b1, 1'b1, Dias32, 1'b0, 32'h48, 32'hA1B2C3D4, 32'h0, 1'b0);
        applyStimulus(1'b1, 1'b0, Dias32, 1'b0, 32'h48, 32'h0, 32'hA1B2C3D4, 1'b0);

        applyStimulus(1'b1, 1'b0, Dias32, 1'b0, 32'h42, 32'h0, 32'h0, 1'b1);
        applyStimulus(1'b0, 1'b0, Dias32, 1'b0, 32'h01, 32'h0, 32'h0, 1'b1);
        applyStimulus(1'b1, 1'b0, Dias16, 1'b1, 32'h23, 32'h0, 32'h0, 1'b1);

        // Contention: ls first, fetch follows after one IDLE cycle.
        e = '{isLs: 1'b1, data: 32'hCAFEF00D, chkData: 1'b1, fault: 1'b0, cycle: cycleCount + 3};
        ackQ.push_back(e);
        e = '{isLs: 1'b0, data: 32'hDEADBEEF, chkData: 1'b1, fault: 1'b0, cycle: cycleCount + 7};
        ackQ.push_back(e);
        s = '{addr: 32'h100, wr: 1'b0, size: Dias32, data: 32'h0, chkData: 1'b0};
        strobeQ.push_back(s);
        s = '{addr: 32'h0, wr: 1'b0, size: Dias32, data: 32'h0, chkData: 1'b0};
        strobeQ.push_back(s);
        strobesPushed += 2;
        busIf.ls_write = 1'b0; busIf.ls_size = Dias32; busIf.ls_signed = 1'b0;
        busIf.ls_addr = 32'h100; busIf.ls_req = 1'b1;
        busIf.fetch_addr = 32'h0; busIf.fetch_req = 1'b1;
        lsSeen = 1'b0; fetchSeen = 1'b0;
        for (int i = 0; i < 40 && !(lsSeen && fetchSeen); i++) begin
            @(negedge clk);
            if (busIf.ls_ack)    begin lsSeen = 1'b1;    busIf.ls_req = 1'b0;    end
            if (busIf.fetch_ack) begin fetchSeen = 1'b1; busIf.fetch_req = 1'b0; end
        end
        if (!(lsSeen && fetchSeen)) checkOutput("contentionTimeout", 32'd0, 32'd1);
        busIf.ls_req = 1'b0; busIf.fetch_req = 1'b0;
        @(negedge clk);

        // Reset during WAIT abandons the fetch: strobe expected, ack not.
        s = '{addr: 32'h10, wr: 1'b0, size: Dias32, data: 32'h0, chkData: 1'b0};
        strobeQ.push_back(s);
        strobesPushed++;
        busIf.fetch_addr = 32'h10; busIf.fetch_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("busyInWait", {31'b0, busIf.busy}, 32'd1);
        #2 rst = 1'b1;
        #1 checkAllZero("asyncReset");
        busIf.fetch_req = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("noAckInReset", {30'b0, busIf.fetch_ack, busIf.ls_ack}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, Dias32, 1'b0, 32'h10, 32'h0, 32'h11223344, 1'b0);

        repeat (3) @(negedge clk);
        checkOutput("strobeTotal", 32'(strobeCount), 32'(strobesPushed));
        checkOutput("ackQueueEmpty", 32'(ackQ.size()), 32'd0);
        checkOutput("strobeQueueEmpty", 32'(strobeQ.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompares);
        $finish;
    end

endmodule
